// File: rtl/ex_mem_if.sv
// EX/MEM pipeline boundary: EX-stage results and controls in, registered MEM-stage view out.
interface ex_mem_if #(
  parameter int unsigned CNT_W = 32
);
  logic             EX_valid;
  logic [31:0]      EX_ALU_result;
  logic [31:0]      EX_pc_4;
  logic [31:0]      EX_pc_imm;
  logic [31:0]      EX_rs2_data;
  logic             EX_rs2_fwd;
  logic [31:0]      EX_rs2_fwd_data;
  logic [1:0]       EX_RegSrc;
  logic [2:0]       EX_funct3;
  logic [4:0]       EX_rs2;
  logic [4:0]       EX_rd;
  logic [2:0]       EX_ValidReg;
  logic             EX_MemRead;
  logic             EX_MemWrite;
  logic             stall;
  logic             flush;

  logic             MEM_valid;
  logic [31:0]      MEM_ALU_result;
  logic [31:0]      MEM_pc_4;
  logic [31:0]      MEM_pc_imm;
  logic [31:0]      MEM_rs2_data;
  logic [1:0]       MEM_RegSrc;
  logic [2:0]       MEM_funct3;
  logic [4:0]       MEM_rs2;
  logic [4:0]       MEM_rd;
  logic [2:0]       MEM_ValidReg;
  logic             MEM_MemRead;
  logic             MEM_MemWrite;
  logic [CNT_W-1:0] bubble_count;

  modport master (
    output EX_valid, EX_ALU_result, EX_pc_4, EX_pc_imm, EX_rs2_data, EX_rs2_fwd,
           EX_rs2_fwd_data, EX_RegSrc, EX_funct3, EX_rs2, EX_rd, EX_ValidReg,
           EX_MemRead, EX_MemWrite, stall, flush,
    input  MEM_valid, MEM_ALU_result, MEM_pc_4, MEM_pc_imm, MEM_rs2_data, MEM_RegSrc,
           MEM_funct3, MEM_rs2, MEM_rd, MEM_ValidReg, MEM_MemRead, MEM_MemWrite,
           bubble_count
  );

  modport slave (
    input  EX_valid, EX_ALU_result, EX_pc_4, EX_pc_imm, EX_rs2_data, EX_rs2_fwd,
           EX_rs2_fwd_data, EX_RegSrc, EX_funct3, EX_rs2, EX_rd, EX_ValidReg,
           EX_MemRead, EX_MemWrite, stall, flush,
    output MEM_valid, MEM_ALU_result, MEM_pc_4, MEM_pc_imm, MEM_rs2_data, MEM_RegSrc,
           MEM_funct3, MEM_rs2, MEM_rd, MEM_ValidReg, MEM_MemRead, MEM_MemWrite,
           bubble_count
  );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with flush > stall > load priority, bubble insertion
// and a saturating count of bubbles pushed into MEM.
module ex_mem_reg #(
  parameter int unsigned CNT_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  ex_mem_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu_result;
    logic [31:0] pc_4;
    logic [31:0] pc_imm;
    logic [31:0] rs2_data;
    logic [1:0]  reg_src;
    logic [2:0]  funct3;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  valid_reg;
    logic        mem_read;
    logic        mem_write;
  } mem_stage_t;

  mem_stage_t       mem_d, mem_q;
  logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
  logic             bubble;

  // Next-state: a bubble is an all-zero stage, so no request can leak downstream.
  always_comb begin
    mem_d        = mem_q;
    bubble_cnt_d = bubble_cnt_q;
    bubble       = 1'b0;

    if (bus.flush) begin
      bubble = 1'b1;
    end else if (!bus.stall) begin
      if (bus.EX_valid) begin
        mem_d.valid      = 1'b1;
        mem_d.alu_result = bus.EX_ALU_result;
        mem_d.pc_4       = bus.EX_pc_4;
        mem_d.pc_imm     = bus.EX_pc_imm;
        mem_d.rs2_data   = bus.EX_rs2_fwd ? bus.EX_rs2_fwd_data : bus.EX_rs2_data;
        mem_d.reg_src    = bus.EX_RegSrc;
        mem_d.funct3     = bus.EX_funct3;
        mem_d.rs2        = bus.EX_rs2;
        mem_d.rd         = bus.EX_rd;
        mem_d.valid_reg  = bus.EX_ValidReg;
        mem_d.mem_read   = bus.EX_MemRead;
        mem_d.mem_write  = bus.EX_MemWrite;
      end else begin
        bubble = 1'b1;
      end
    end

    if (bubble) begin
      mem_d = '0;
      if (bubble_cnt_q != CNT_MAX) begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q        <= '0;
      bubble_cnt_q <= '0;
    end else begin
      mem_q        <= mem_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.MEM_valid      = mem_q.valid;
  assign bus.MEM_ALU_result = mem_q.alu_result;
  assign bus.MEM_pc_4       = mem_q.pc_4;
  assign bus.MEM_pc_imm     = mem_q.pc_imm;
  assign bus.MEM_rs2_data   = mem_q.rs2_data;
  assign bus.MEM_RegSrc     = mem_q.reg_src;
  assign bus.MEM_funct3     = mem_q.funct3;
  assign bus.MEM_rs2        = mem_q.rs2;
  assign bus.MEM_rd         = mem_q.rd;
  assign bus.MEM_ValidReg   = mem_q.valid_reg;
  assign bus.MEM_MemRead    = mem_q.mem_read;
  assign bus.MEM_MemWrite   = mem_q.mem_write;
  assign bus.bubble_count   = bubble_cnt_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg (4-bit bubble counter so saturation is reachable).
module tb_ex_mem_reg;

  localparam int unsigned CNT_W = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  ex_mem_if #(.CNT_W(CNT_W)) bus ();

  ex_mem_reg #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"},    32'(bus.MEM_valid),      32'd0);
    check({tag, ".alu"},      bus.MEM_ALU_result,      32'd0);
    check({tag, ".pc4"},      bus.MEM_pc_4,            32'd0);
    check({tag, ".pcimm"},    bus.MEM_pc_imm,          32'd0);
    check({tag, ".rs2data"},  bus.MEM_rs2_data,        32'd0);
    check({tag, ".regsrc"},   32'(bus.MEM_RegSrc),     32'd0);
    check({tag, ".funct3"},   32'(bus.MEM_funct3),     32'd0);
    check({tag, ".rs2"},      32'(bus.MEM_rs2),        32'd0);
    check({tag, ".rd"},       32'(bus.MEM_rd),         32'd0);
    check({tag, ".validreg"}, 32'(bus.MEM_ValidReg),   32'd0);
    check({tag, ".memrd"},    32'(bus.MEM_MemRead),    32'd0);
    check({tag, ".memwr"},    32'(bus.MEM_MemWrite),   32'd0);
    check({tag, ".bubbles"},  32'(bus.bubble_count),   32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.EX_valid = 1'b0;        bus.EX_ALU_result = '0;   bus.EX_pc_4 = '0;
    bus.EX_pc_imm = '0;         bus.EX_rs2_data = '0;     bus.EX_rs2_fwd = 1'b0;
    bus.EX_rs2_fwd_data = '0;   bus.EX_RegSrc = '0;       bus.EX_funct3 = '0;
    bus.EX_rs2 = '0;            bus.EX_rd = '0;           bus.EX_ValidReg = '0;
    bus.EX_MemRead = 1'b0;      bus.EX_MemWrite = 1'b0;
    bus.stall = 1'b0;           bus.flush = 1'b0;

    step();
    step();
    check_all_zero("reset");

    // Basic load, set up before reset release so the first capture is real.
    bus.EX_valid = 1'b1;        bus.EX_ALU_result = 32'h0000_1234;
    bus.EX_pc_4 = 32'h0000_0104; bus.EX_pc_imm = 32'h0000_0200;
    bus.EX_RegSrc = 2'd2;       bus.EX_funct3 = 3'b010;   bus.EX_rs2 = 5'd7;
    bus.EX_rd = 5'd5;           bus.EX_ValidReg = 3'b001; bus.EX_MemRead = 1'b1;
    bus.EX_rs2_data = 32'h0000_00AB;
    rst = 1'b0;
    check("no_capture_before_edge", 32'(bus.MEM_valid), 32'd0);
    step();
    check("load.alu",      bus.MEM_ALU_result,    32'h0000_1234);
    check("load.rd",       32'(bus.MEM_rd),       32'd5);
    check("load.validreg", 32'(bus.MEM_ValidReg), 32'b001);
    check("load.valid",    32'(bus.MEM_valid),    32'd1);
    check("load.pc4",      bus.MEM_pc_4,          32'h0000_0104);
    check("load.pcimm",    bus.MEM_pc_imm,        32'h0000_0200);
    check("load.regsrc",   32'(bus.MEM_RegSrc),   32'd2);
    check("load.funct3",   32'(bus.MEM_funct3),   32'd2);
    check("load.rs2",      32'(bus.MEM_rs2),      32'd7);
    check("load.memrd",    32'(bus.MEM_MemRead),  32'd1);
    check("load.rs2data",  bus.MEM_rs2_data,      32'h0000_00AB);
    check("load.bubbles",  32'(bus.bubble_count), 32'd0);

    // Store data selection between forwarded and register-file value.
    bus.EX_MemRead = 1'b0;      bus.EX_MemWrite = 1'b1;
    bus.EX_rs2_data = 32'hAAAA_AAAA;
    bus.EX_rs2_fwd = 1'b1;      bus.EX_rs2_fwd_data = 32'h5555_5555;
    step();
    check("store_fwd.data",  bus.MEM_rs2_data,     32'h5555_5555);
    check("store_fwd.memwr", 32'(bus.MEM_MemWrite), 32'd1);
    check("store_fwd.memrd", 32'(bus.MEM_MemRead),  32'd0);
    bus.EX_rs2_fwd = 1'b0;
    step();
    check("store_rf.data", bus.MEM_rs2_data, 32'hAAAA_AAAA);

    // Instruction A, then stall with changing EX inputs (including a non-valid slot).
    bus.EX_MemWrite = 1'b0;     bus.EX_MemRead = 1'b1;
    bus.EX_ALU_result = 32'h0000_A0A0; bus.EX_rd = 5'd9; bus.EX_ValidReg = 3'b111;
    step();
    check("instr_a.alu", bus.MEM_ALU_result, 32'h0000_A0A0);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.EX_ALU_result = 32'hFFFF_0000 + 32'(i);
      bus.EX_rd = 5'd1;
      bus.EX_MemRead = 1'b0;
      bus.EX_valid = (i != 1);
      step();
      check($sformatf("stall%0d.alu", i),     bus.MEM_ALU_result,    32'h0000_A0A0);
      check($sformatf("stall%0d.rd", i),      32'(bus.MEM_rd),       32'd9);
      check($sformatf("stall%0d.valid", i),   32'(bus.MEM_valid),    32'd1);
      check($sformatf("stall%0d.memrd", i),   32'(bus.MEM_MemRead),  32'd1);
      check($sformatf("stall%0d.bubbles", i), 32'(bus.bubble_count), 32'd0);
    end
    bus.flush = 1'b1;
    step();
    check("stall_flush.valid",    32'(bus.MEM_valid),    32'd0);
    check("stall_flush.memrd",    32'(bus.MEM_MemRead),  32'd0);
    check("stall_flush.validreg", 32'(bus.MEM_ValidReg), 32'd0);
    check("stall_flush.alu",      bus.MEM_ALU_result,    32'd0);
    check("stall_flush.bubbles",  32'(bus.bubble_count), 32'd1);

    // rd=0 with ValidReg[0]=1 passes through untouched.
    bus.stall = 1'b0;  bus.flush = 1'b0;  bus.EX_valid = 1'b1;
    bus.EX_rd = 5'd0;  bus.EX_ValidReg = 3'b001;  bus.EX_ALU_result = 32'h0000_0042;
    step();
    check("x0.rd",       32'(bus.MEM_rd),       32'd0);
    check("x0.validreg", 32'(bus.MEM_ValidReg), 32'b001);
    check("x0.valid",    32'(bus.MEM_valid),    32'd1);

    // Flush squashes a valid instruction.
    bus.flush = 1'b1;  bus.EX_MemWrite = 1'b1;
    step();
    check("flush.valid",   32'(bus.MEM_valid),    32'd0);
    check("flush.memwr",   32'(bus.MEM_MemWrite), 32'd0);
    check("flush.bubbles", 32'(bus.bubble_count), 32'd2);

    // Invalid EX slot inserts a bubble.
    bus.flush = 1'b0;  bus.EX_valid = 1'b0;
    step();
    check("bubble.valid",   32'(bus.MEM_valid),    32'd0);
    check("bubble.memwr",   32'(bus.MEM_MemWrite), 32'd0);
    check("bubble.alu",     bus.MEM_ALU_result,    32'd0);
    check("bubble.bubbles", 32'(bus.bubble_count), 32'd3);

    // Async reset mid-cycle, with stall held across it.
    bus.EX_valid = 1'b1;  bus.EX_MemWrite = 1'b0;  bus.EX_MemRead = 1'b1;
    step();
    check("prerst.memrd",   32'(bus.MEM_MemRead),  32'd1);
    check("prerst.valid",   32'(bus.MEM_valid),    32'd1);
    check("prerst.bubbles", 32'(bus.bubble_count), 32'd3);
    #2;
    bus.stall = 1'b1;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    bus.stall = 1'b0;
    step();
    step();
    check_all_zero("rst_held");
    bus.stall = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    check_all_zero("stall_after_rst");

    // Saturation of the 4-bit bubble counter.
    bus.stall = 1'b0;  bus.EX_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 10) check("sat.c10", 32'(bus.bubble_count), 32'd10);
      if (i == 15) check("sat.c15", 32'(bus.bubble_count), 32'd15);
      if (i == 16) check("sat.c16", 32'(bus.bubble_count), 32'd15);
    end
    check("sat.c20", 32'(bus.bubble_count), 32'd15);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
